// File: rtl/mem_array_pkg.sv
// Shared op codes, sequencer states and default geometry for the memory-array sequencer.
package mem_array_pkg;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_READ  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_ACCUM = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RDBL   = 3'd2,
    S_CLEAR  = 3'd3,
    S_ACC_RD = 3'd4,
    S_ACC_WR = 3'd5,
    S_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/bit_serial_adder.sv
// One-bit full adder with a carry flop; processes one row of the serial word per enable.
module bit_serial_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  logic cout;

  assign sum  = a ^ b ^ carry;
  assign cout = (a & b) | (carry & (a ^ b));

  // Carry flop: cleared at the start of a new accumulation, advanced once per row.
  always_ff @(posedge clk) begin
    if (!rst_n)   carry <= 1'b0;
    else if (clr) carry <= 1'b0;
    else if (en)  carry <= cout;
  end

endmodule

// File: rtl/mem_array_serial_ctrl.sv
// Command sequencer driving the 8x8 memory array control lines (GWL/Write/READ/Clr,
// RWL/WWL) and the bit-serial add-back loop between ToAdder and FromAdder.
module mem_array_serial_ctrl
  import mem_array_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              carry_out,
  output logic [DATA_W-1:0] DataIn,
  output logic [ROWS-1:0]   RWL,
  output logic [ROWS-1:0]   WWL,
  output logic              GWL,
  output logic              READ,
  output logic              Write,
  output logic              Clr,
  output logic              FromAdder,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              ToAdder
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e            state;
  logic [RW-1:0]     row;
  logic [RW-1:0]     row_nxt;
  logic [DATA_W-1:0] data_lat;
  logic              add_b;
  logic              add_sum;
  logic              add_carry;
  logic              add_clr;
  logic              add_en;

  // Addend bit for a row; rows beyond the data width add zero.
  function automatic logic addend_bit(input logic [DATA_W-1:0] d, input logic [RW-1:0] r);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == int'(r)) b = d[i];
    end
    return b;
  endfunction

  // One-hot wordline decode of a row index.
  function automatic logic [ROWS-1:0] onehot(input logic [RW-1:0] r);
    logic [ROWS-1:0] v;
    for (int i = 0; i < ROWS; i++) begin
      v[i] = (i == int'(r));
    end
    return v;
  endfunction

  assign row_nxt = row + 1'b1;
  assign add_b   = addend_bit(data_lat, row);
  assign add_clr = (state == S_IDLE) && cmd_valid && cmd_ready && (op_e'(cmd_op) == OP_ACCUM);
  assign add_en  = (state == S_ACC_RD);

  bit_serial_adder u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (add_clr),
    .en    (add_en),
    .a     (ToAdder),
    .b     (add_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Sequencer FSM; every array control line is a registered output of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      data_lat  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      carry_out <= 1'b0;
      DataIn    <= '0;
      RWL       <= '0;
      WWL       <= '0;
      GWL       <= 1'b0;
      READ      <= 1'b0;
      Write     <= 1'b0;
      Clr       <= 1'b0;
      FromAdder <= 1'b0;
    end else begin
      done      <= 1'b0;
      DataIn    <= '0;
      RWL       <= '0;
      WWL       <= '0;
      GWL       <= 1'b0;
      READ      <= 1'b0;
      Write     <= 1'b0;
      Clr       <= 1'b0;
      FromAdder <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            data_lat  <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (op_e'(cmd_op))
              OP_LOAD: begin
                state  <= S_LOAD;
                GWL    <= 1'b1;
                Write  <= 1'b1;
                DataIn <= cmd_data;
              end
              OP_READ: begin
                state <= S_RDBL;
                GWL   <= 1'b1;
                READ  <= 1'b1;
              end
              OP_CLEAR: begin
                state <= S_CLEAR;
                Clr   <= 1'b1;
              end
              default: begin
                state     <= S_ACC_RD;
                row       <= '0;
                carry_out <= 1'b0;
                RWL       <= onehot('0);
              end
            endcase
          end
        end
        S_LOAD, S_CLEAR: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_RDBL: begin
          rd_data <= DataOut;
          state   <= S_DONE;
          done    <= 1'b1;
        end
        S_ACC_RD: begin
          FromAdder <= add_sum;
          WWL       <= onehot(row);
          state     <= S_ACC_WR;
        end
        S_ACC_WR: begin
          if (int'(row) == ROWS - 1) begin
            carry_out <= add_carry;
            state     <= S_DONE;
            done      <= 1'b1;
          end else begin
            row   <= row_nxt;
            RWL   <= onehot(row_nxt);
            state <= S_ACC_RD;
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
